wb_write_arbiter: RTL and testbench

Arbitrates the single register-file write port between the pipeline writeback stage (`FinalWriteData`) and results returning from long-latency execution units (multiply/divide). Long-latency results are buffered in a small FIFO and drained in cycles the pipeline leaves the port idle. A starvation counter forces a drain by stalling the pipeline's writeback when needed. The block sits between the writeBack stage and the register file; its outputs drive the register-file write port directly.

---
 rtl/wb_write_arbiter.sv | 174 +++++++++++++++++
 tb/tb_wb_write_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter: shares the single register-file write port between the
// writeback stage and results returning from long-latency units (mul/div).
// Long-latency results queue in a small FIFO and drain in cycles the pipeline
// leaves the port idle. A starvation counter, or a full FIFO with another
// result waiting, forces a one-cycle drain that stalls the writeback stage.
// Optional feature: define WB_ARB_BYPASS_EN to let a long-latency result skip
// the empty FIFO and write directly when the port is otherwise idle.
module wb_write_arbiter #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned DATA_W       = 64,
    parameter int unsigned ADDR_W       = 5,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     pipe_wr_en,
    input  logic [ADDR_W-1:0]        pipe_wr_addr,
    input  logic [DATA_W-1:0]        pipe_wr_data,
    output logic                     pipe_stall,
    input  logic                     lu_valid,
    output logic                     lu_ready,
    input  logic [ADDR_W-1:0]        lu_addr,
    input  logic [DATA_W-1:0]        lu_data,
    output logic                     rf_wr_en,
    output logic [ADDR_W-1:0]        rf_wr_addr,
    output logic [DATA_W-1:0]        rf_wr_data,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SC_W  = $clog2(STARVE_LIMIT + 1);

    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [SC_W-1:0]   LIMIT_CNT = SC_W'(STARVE_LIMIT);
    localparam logic [ADDR_W-1:0] XZR       = ADDR_W'(31);

    localparam logic [0:0] NORMAL = 1'b0;
    localparam logic [0:0] FORCE  = 1'b1;

    logic [0:0]        stateQ, stateD;
    logic [SC_W-1:0]   starveCntQ, starveCntD;
    logic [PTR_W-1:0]  wrPtrQ, rdPtrQ;
    logic [CNT_W-1:0]  countQ;

    logic [ADDR_W-1:0] addrMem [DEPTH];
    logic [DATA_W-1:0] dataMem [DEPTH];

    logic              fifoEmpty;
    logic              fifoFull;
    logic              pipeReal;
    logic              bypassGrant;
    logic              push;
    logic              pop;
    logic              grantValid;
    logic [ADDR_W-1:0] grantAddr;
    logic [DATA_W-1:0] grantData;
    logic              grantWrite;

    assign fifoEmpty  = (countQ == '0);
    assign fifoFull   = (countQ == FULL_CNT);
    assign lu_ready   = (countQ < FULL_CNT);
    assign pipe_stall = (stateQ == FORCE);
    assign fifo_count = countQ;

    // A write to XZR is a no-op, so it never blocks the FIFO head.
    assign pipeReal = pipe_wr_en && (pipe_wr_addr != XZR);

`ifdef WB_ARB_BYPASS_EN
    assign bypassGrant = (stateQ == NORMAL) && fifoEmpty && lu_valid && !pipeReal;
`else
    assign bypassGrant = 1'b0;
`endif

    // A bypassed result is written directly and never enters the FIFO.
    assign push = lu_valid && lu_ready && !bypassGrant;

    // Select which source owns the write port this cycle.
    always_comb begin
        grantValid = 1'b0;
        grantAddr  = pipe_wr_addr;
        grantData  = pipe_wr_data;
        pop        = 1'b0;
        if (stateQ == FORCE) begin
            if (!fifoEmpty) begin
                grantValid = 1'b1;
                grantAddr  = addrMem[rdPtrQ];
                grantData  = dataMem[rdPtrQ];
                pop        = 1'b1;
            end
        end else if (pipeReal) begin
            grantValid = 1'b1;
        end else if (!fifoEmpty) begin
            grantValid = 1'b1;
            grantAddr  = addrMem[rdPtrQ];
            grantData  = dataMem[rdPtrQ];
            pop        = 1'b1;
        end else if (bypassGrant) begin
            grantValid = 1'b1;
            grantAddr  = lu_addr;
            grantData  = lu_data;
        end
    end

    assign grantWrite = grantValid && (grantAddr != XZR);

    // Arbitration state and starvation tracking.
    always_comb begin
        stateD     = NORMAL;
        starveCntD = '0;
        if (stateQ == FORCE) begin
            // A forced drain may repeat only while the FIFO is still full and backed up.
            if (fifoFull && lu_valid) begin
                stateD = FORCE;
            end
        end else begin
            if (pipeReal && !fifoEmpty && (starveCntQ != LIMIT_CNT)) begin
                starveCntD = starveCntQ + SC_W'(1);
            end
            if (!fifoEmpty && ((starveCntD == LIMIT_CNT) || (fifoFull && lu_valid))) begin
                stateD = FORCE;
            end
        end
    end

    // State, counter and FIFO pointers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stateQ     <= NORMAL;
            starveCntQ <= '0;
            wrPtrQ     <= '0;
            rdPtrQ     <= '0;
            countQ     <= '0;
        end else begin
            stateQ     <= stateD;
            starveCntQ <= starveCntD;
            if (push) begin
                wrPtrQ <= wrPtrQ + PTR_W'(1);
            end
            if (pop) begin
                rdPtrQ <= rdPtrQ + PTR_W'(1);
            end
            if (push && !pop) begin
                countQ <= countQ + CNT_W'(1);
            end else if (pop && !push) begin
                countQ <= countQ - CNT_W'(1);
            end
        end
    end

    // FIFO storage; contents are meaningless outside the pointer window.
    always_ff @(posedge clk) begin
        if (push) begin
            addrMem[wrPtrQ] <= lu_addr;
            dataMem[wrPtrQ] <= lu_data;
        end
    end

    // Registered register-file write port.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rf_wr_en   <= 1'b0;
            rf_wr_addr <= '0;
            rf_wr_data <= '0;
        end else begin
            rf_wr_en <= grantWrite;
            if (grantWrite) begin
                rf_wr_addr <= grantAddr;
                rf_wr_data <= grantData;
            end
        end
    end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Self-checking bench for wb_write_arbiter: a queue-based reference model is
// compared against the DUT every cycle, with directed scenarios that pin the
// model to hand-derived values, followed by a randomized phase.
module tb_wb_write_arbiter;

    localparam int DEPTH        = 4;
    localparam int DATA_W       = 64;
    localparam int ADDR_W       = 5;
    localparam int STARVE_LIMIT = 4;

    logic                   clk = 1'b0;
    logic                   reset_n;
    logic                   pipe_wr_en;
    logic [ADDR_W-1:0]      pipe_wr_addr;
    logic [DATA_W-1:0]      pipe_wr_data;
    logic                   pipe_stall;
    logic                   lu_valid;
    logic                   lu_ready;
    logic [ADDR_W-1:0]      lu_addr;
    logic [DATA_W-1:0]      lu_data;
    logic                   rf_wr_en;
    logic [ADDR_W-1:0]      rf_wr_addr;
    logic [DATA_W-1:0]      rf_wr_data;
    logic [$clog2(DEPTH):0] fifo_count;

    always #5 clk = ~clk;

    wb_write_arbiter #(
        .DEPTH        (DEPTH),
        .DATA_W       (DATA_W),
        .ADDR_W       (ADDR_W),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .pipe_wr_en   (pipe_wr_en),
        .pipe_wr_addr (pipe_wr_addr),
        .pipe_wr_data (pipe_wr_data),
        .pipe_stall   (pipe_stall),
        .lu_valid     (lu_valid),
        .lu_ready     (lu_ready),
        .lu_addr      (lu_addr),
        .lu_data      (lu_data),
        .rf_wr_en     (rf_wr_en),
        .rf_wr_addr   (rf_wr_addr),
        .rf_wr_data   (rf_wr_data),
        .fifo_count   (fifo_count)
    );

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } ent_t;

    // Reference model state
    ent_t              mQ[$];
    bit                mForce;
    int                mStarve;
    bit                mLuAcc;
    bit                expEn;
    logic [ADDR_W-1:0] expAddr;
    logic [DATA_W-1:0] expData;

    int nCmp  = 0;
    int nFail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCmp++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic checkModel();
        check("rf_wr_en", 64'(rf_wr_en), 64'(expEn));
        if (expEn) begin
            check("rf_wr_addr", 64'(rf_wr_addr), 64'(expAddr));
            check("rf_wr_data", rf_wr_data, expData);
        end
        check("pipe_stall", 64'(pipe_stall), 64'(mForce));
        check("lu_ready", 64'(lu_ready), 64'(mQ.size() < DEPTH));
        check("fifo_count", 64'(fifo_count), 64'(mQ.size()));
    endtask

    task automatic modelReset();
        mQ.delete();
        mForce  = 0;
        mStarve = 0;
        mLuAcc  = 0;
        expEn   = 0;
        expAddr = '0;
        expData = '0;
    endtask

    // One clock of behaviour: who writes, what the queue holds, whether the next cycle stalls.
    task automatic modelStep(input logic pe, input logic [ADDR_W-1:0] pa,
                             input logic [DATA_W-1:0] pd, input logic lv,
                             input logic [ADDR_W-1:0] la, input logic [DATA_W-1:0] ld);
        int   sz       = mQ.size();
        bit   full     = (sz == DEPTH);
        bit   pipeReal = pe && (pa != 5'd31);
        bit   byp      = 0;
        bit   g        = 0;
        ent_t ge;
        ge.a = '0;
        ge.d = '0;
`ifdef WB_ARB_BYPASS_EN
        byp = !mForce && !pipeReal && (sz == 0) && lv;
`endif
        if (mForce) begin
            if (sz > 0) begin
                ge = mQ.pop_front();
                g  = 1;
            end
        end else if (pipeReal) begin
            ge.a = pa;
            ge.d = pd;
            g    = 1;
        end else if (sz > 0) begin
            ge = mQ.pop_front();
            g  = 1;
        end else if (byp) begin
            ge.a = la;
            ge.d = ld;
            g    = 1;
        end
        mLuAcc = lv && (sz < DEPTH);
        if (mLuAcc && !byp) begin
            ent_t e;
            e.a = la;
            e.d = ld;
            mQ.push_back(e);
        end
        if (mForce) begin
            mStarve = 0;
            mForce  = full && lv;
        end else begin
            if (pipeReal && sz > 0) mStarve = mStarve + 1;
            else mStarve = 0;
            mForce = (sz > 0) && ((mStarve >= STARVE_LIMIT) || (full && lv));
            if (mForce) mStarve = 0;
        end
        expEn = g && (ge.a != 5'd31);
        if (expEn) begin
            expAddr = ge.a;
            expData = ge.d;
        end
    endtask

    // Drive one cycle of inputs (caller sits at a falling edge), then check at the next one.
    task automatic tick(input logic pe, input logic [ADDR_W-1:0] pa,
                        input logic [DATA_W-1:0] pd, input logic lv,
                        input logic [ADDR_W-1:0] la, input logic [DATA_W-1:0] ld);
        pipe_wr_en   = pe;
        pipe_wr_addr = pa;
        pipe_wr_data = pd;
        lu_valid     = lv;
        lu_addr      = la;
        lu_data      = ld;
        modelStep(pe, pa, pd, lv, la, ld);
        @(negedge clk);
        checkModel();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [ADDR_W-1:0] got[$];
        logic              rpe;
        logic [ADDR_W-1:0] rpa;
        logic [DATA_W-1:0] rpd;
        logic              luPend;
        logic [ADDR_W-1:0] rla;
        logic [DATA_W-1:0] rld;

        reset_n      = 1'b0;
        pipe_wr_en   = 1'b0;
        pipe_wr_addr = '0;
        pipe_wr_data = '0;
        lu_valid     = 1'b0;
        lu_addr      = '0;
        lu_data      = '0;
        modelReset();
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset values
        check("rst_rf_wr_en", 64'(rf_wr_en), 64'd0);
        check("rst_rf_wr_addr", 64'(rf_wr_addr), 64'd0);
        check("rst_rf_wr_data", rf_wr_data, 64'd0);
        check("rst_pipe_stall", 64'(pipe_stall), 64'd0);
        check("rst_fifo_count", 64'(fifo_count), 64'd0);
        check("rst_lu_ready", 64'(lu_ready), 64'd1);
        reset_n = 1'b1;

        // Pipeline only
        tick(1'b1, 5'd5, 64'hAA, 1'b0, 5'd0, 64'd0);
        check("pipe_en", 64'(rf_wr_en), 64'd1);
        check("pipe_addr", 64'(rf_wr_addr), 64'd5);
        check("pipe_data", rf_wr_data, 64'hAA);
        tick(1'b1, 5'd5, 64'hAA, 1'b0, 5'd0, 64'd0);
        tick(1'b1, 5'd5, 64'hAA, 1'b0, 5'd0, 64'd0);
        check("pipe_nostall", 64'(pipe_stall), 64'd0);

        // Idle drain
        tick(1'b0, 5'd0, 64'd0, 1'b1, 5'd7, 64'd99);
`ifdef WB_ARB_BYPASS_EN
        check("bypass_en", 64'(rf_wr_en), 64'd1);
        check("bypass_addr", 64'(rf_wr_addr), 64'd7);
        check("bypass_data", rf_wr_data, 64'd99);
        check("bypass_count", 64'(fifo_count), 64'd0);
`else
        check("drain_n1_en", 64'(rf_wr_en), 64'd0);
        check("drain_n1_count", 64'(fifo_count), 64'd1);
        tick(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
        check("drain_n2_en", 64'(rf_wr_en), 64'd1);
        check("drain_n2_addr", 64'(rf_wr_addr), 64'd7);
        check("drain_n2_data", rf_wr_data, 64'd99);
        check("drain_n2_count", 64'(fifo_count), 64'd0);
`endif
        idle(2);

        // Starvation: one entry waits four cycles, then a single forced drain
        tick(1'b1, 5'd3, 64'h11, 1'b1, 5'd9, 64'h55);
        for (int i = 0; i < 3; i++) tick(1'b1, 5'd3, 64'h11, 1'b0, 5'd0, 64'd0);
        check("starve_nostall", 64'(pipe_stall), 64'd0);
        tick(1'b1, 5'd3, 64'h11, 1'b0, 5'd0, 64'd0);
        check("starve_stall", 64'(pipe_stall), 64'd1);
        tick(1'b1, 5'd3, 64'h22, 1'b0, 5'd0, 64'd0);
        check("starve_lu_addr", 64'(rf_wr_addr), 64'd9);
        check("starve_lu_data", rf_wr_data, 64'h55);
        check("starve_unstall", 64'(pipe_stall), 64'd0);
        tick(1'b1, 5'd3, 64'h22, 1'b0, 5'd0, 64'd0);
        check("starve_held_data", rf_wr_data, 64'h22);
        idle(2);

        // Full FIFO under continuous pipeline writes; drained in order
        for (int k = 0; k < 4; k++)
            tick(1'b1, 5'd4, 64'(k), 1'b1, 5'(10 + k), 64'(100 + k));
        check("full_count", 64'(fifo_count), 64'd4);
        check("full_ready", 64'(lu_ready), 64'd0);
        tick(1'b1, 5'd4, 64'd50, 1'b1, 5'd14, 64'd114);
        check("full_force", 64'(pipe_stall), 64'd1);
        got.delete();
        for (int i = 0; i < 40; i++) begin
            tick(1'b1, 5'd4, 64'd50, 1'b0, 5'd0, 64'd0);
            if (rf_wr_en && rf_wr_addr >= 5'd10) got.push_back(rf_wr_addr);
        end
        check("full_drain_cnt", 64'(got.size()), 64'd4);
        for (int k = 0; k < 4; k++)
            if (k < got.size()) check("full_drain_order", 64'(got[k]), 64'(10 + k));
        idle(2);

        // XZR: pipeline addr 31 does not block the FIFO head; an addr-31 entry is dropped
        tick(1'b1, 5'd2, 64'h1, 1'b1, 5'd20, 64'h77);
        tick(1'b1, 5'd31, 64'h33, 1'b0, 5'd0, 64'd0);
        check("xzr_head_en", 64'(rf_wr_en), 64'd1);
        check("xzr_head_addr", 64'(rf_wr_addr), 64'd20);
        check("xzr_head_data", rf_wr_data, 64'h77);
        tick(1'b1, 5'd2, 64'h1, 1'b1, 5'd31, 64'h44);
        tick(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
        check("xzr_lu_en", 64'(rf_wr_en), 64'd0);
        check("xzr_lu_count", 64'(fifo_count), 64'd0);
        idle(2);

        // Reset mid-operation with three entries queued
        for (int k = 0; k < 3; k++)
            tick(1'b1, 5'd2, 64'(k), 1'b1, 5'(24 + k), 64'(k));
        check("mrst_pre_count", 64'(fifo_count), 64'd3);
        reset_n = 1'b0;
        #1;
        check("mrst_count", 64'(fifo_count), 64'd0);
        check("mrst_en", 64'(rf_wr_en), 64'd0);
        check("mrst_ready", 64'(lu_ready), 64'd1);
        pipe_wr_en = 1'b0;
        lu_valid   = 1'b0;
        modelReset();
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        idle(3);
        check("mrst_no_stale", 64'(rf_wr_en), 64'd0);

        // Randomized traffic; stalled pipeline writes and unaccepted results are held
        rpe    = 1'b0;
        rpa    = '0;
        rpd    = '0;
        luPend = 1'b0;
        rla    = '0;
        rld    = '0;
        for (int i = 0; i < 800; i++) begin
            int luPct;
            luPct = (((i / 100) % 2) == 1) ? 85 : 30;
            if (!mForce) begin
                rpe = ($urandom_range(0, 99) < 70);
                rpa = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 30));
                rpd = {$urandom, $urandom};
            end
            if (!luPend && ($urandom_range(0, 99) < luPct)) begin
                luPend = 1'b1;
                rla    = 5'($urandom_range(0, 31));
                rld    = {$urandom, $urandom};
            end
            tick(rpe, rpa, rpd, luPend, rla, rld);
            if (mLuAcc) luPend = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", nCmp, nFail);
        $finish;
    end

endmodule
